// File: rtl/elastic_rr_arbiter_if.sv
// Handshake bundle between num_req_p producers, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface elastic_rr_arbiter_if #(
   parameter int unsigned width_p   = 8,
   parameter int unsigned num_req_p = 4
);
   localparam int unsigned Idw = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   logic [num_req_p-1:0]         req_valid;
   logic [num_req_p*width_p-1:0] req_data;
   logic [num_req_p-1:0]         req_last;
   logic [num_req_p-1:0]         req_ready;
   logic                         out_valid;
   logic [width_p-1:0]           out_data;
   logic                         out_last;
   logic [Idw-1:0]               out_grant_id;
   logic                         out_ready;

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, out_grant_id
   );

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_grant_id
   );
endinterface

// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage, with optional
// packet locking so a granted requester keeps the stage until its last beat.
module elastic_rr_arbiter #(
   parameter int unsigned width_p        = 8,
   parameter int unsigned num_req_p      = 4,
   parameter bit          lock_packets_p = 1'b1
) (
   input logic                 clk_i,
   input logic                 reset_ni,
   elastic_rr_arbiter_if.slave bus_if
);
   localparam int unsigned Idw = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam logic [Idw-1:0] LastId = Idw'(num_req_p - 1);

   typedef enum logic {StIdle, StLocked} state_e;

   state_e               state_q, state_d;
   logic [Idw-1:0]       ptr_q, ptr_d;
   logic [Idw-1:0]       lock_id_q, lock_id_d;
   logic                 valid_q, valid_d;
   logic [width_p-1:0]   data_q, data_d;
   logic                 last_q, last_d;
   logic [Idw-1:0]       gid_q, gid_d;

   logic                 accept;
   logic                 grant_found;
   logic [Idw-1:0]       grant_id;
   int unsigned          scan_idx;
   logic [width_p-1:0]   sel_data;
   logic                 sel_last;
   logic                 sel_valid;
   logic                 xfer;
   logic [num_req_p-1:0] ready;

   function automatic logic [Idw-1:0] next_id(input logic [Idw-1:0] id);
      return (id == LastId) ? '0 : id + 1'b1;
   endfunction

   assign accept = ~valid_q | bus_if.out_ready;

   // Search from ptr_q upward; a locked owner keeps the grant even while idle.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = 0;
      if (state_q == StLocked) begin
         grant_found = 1'b1;
         grant_id    = lock_id_q;
      end else begin
         for (int unsigned i = 0; i < num_req_p; i++) begin
            scan_idx = (int'(ptr_q) + i) % num_req_p;
            if (!grant_found && bus_if.req_valid[scan_idx]) begin
               grant_found = 1'b1;
               grant_id    = Idw'(scan_idx);
            end
         end
      end
   end

   // One-hot select so non-granted data never reaches the output register.
   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      ready     = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         if (grant_id == Idw'(k)) begin
            sel_data  = bus_if.req_data[k*width_p +: width_p];
            sel_last  = bus_if.req_last[k];
            sel_valid = bus_if.req_valid[k];
            ready[k]  = accept & grant_found;
         end
      end
   end

   assign xfer = accept & grant_found & sel_valid;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      lock_id_d = lock_id_q;
      valid_d   = valid_q;
      data_d    = data_q;
      last_d    = last_q;
      gid_d     = gid_q;
      if (accept) begin
         valid_d = xfer;
         if (xfer) begin
            data_d = sel_data;
            last_d = sel_last;
            gid_d  = grant_id;
         end
      end
      if (xfer) begin
         if (!lock_packets_p) begin
            ptr_d = next_id(grant_id);
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (sel_last) begin
                     ptr_d = next_id(grant_id);
                  end else begin
                     state_d   = StLocked;
                     lock_id_d = grant_id;
                  end
               end
               StLocked: begin
                  if (sel_last) begin
                     state_d = StIdle;
                     ptr_d   = next_id(lock_id_q);
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         lock_id_q <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         last_q    <= 1'b0;
         gid_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         lock_id_q <= lock_id_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         last_q    <= last_d;
         gid_q     <= gid_d;
      end
   end

   assign bus_if.req_ready    = ready;
   assign bus_if.out_valid    = valid_q;
   assign bus_if.out_data     = data_q;
   assign bus_if.out_last     = last_q;
   assign bus_if.out_grant_id = gid_q;
endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Directed bench: a locking instance and a per-beat rotating instance driven from
// hand-written vectors with hand-computed expected outputs.
module tb_elastic_rr_arbiter;
   localparam int unsigned W = 8;
   localparam int unsigned N = 4;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_err;

   elastic_rr_arbiter_if #(.width_p(W), .num_req_p(N)) lk_if ();
   elastic_rr_arbiter_if #(.width_p(W), .num_req_p(N)) rr_if ();

   elastic_rr_arbiter #(.width_p(W), .num_req_p(N), .lock_packets_p(1'b1)) u_lock (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus_if   (lk_if.slave)
   );

   elastic_rr_arbiter #(.width_p(W), .num_req_p(N), .lock_packets_p(1'b0)) u_rot (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus_if   (rr_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_lk_out(input string tag, input logic v, input logic [7:0] d,
                               input logic l, input logic [1:0] g);
      check_eq({tag, ".valid"}, 32'(lk_if.out_valid), 32'(v));
      check_eq({tag, ".data"}, 32'(lk_if.out_data), 32'(d));
      check_eq({tag, ".last"}, 32'(lk_if.out_last), 32'(l));
      check_eq({tag, ".gid"}, 32'(lk_if.out_grant_id), 32'(g));
   endtask

   task automatic set_lk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
      lk_if.req_valid = v;
      lk_if.req_last  = l;
      lk_if.req_data  = d;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      set_lk(4'b0000, 4'b0000, 32'h0);
      lk_if.out_ready = 1'b1;
      rr_if.req_valid = '0;
      rr_if.req_last  = '0;
      rr_if.req_data  = '0;
      rr_if.out_ready = 1'b1;
      #12;
      reset_n = 1'b1;

      // 1: idle after reset
      for (int c = 0; c < 10; c++) begin
         check_eq("idle.ready", 32'(lk_if.req_ready), 32'h0);
         tick();
         check_lk_out("idle", 1'b0, 8'h00, 1'b0, 2'd0);
      end

      // 2: rotate every beat, all requesters valid
      rr_if.req_valid = 4'b1111;
      rr_if.req_last  = 4'b1111;
      rr_if.req_data  = 32'hA3A2A1A0;
      #1;
      check_eq("rot.ready0", 32'(rr_if.req_ready), 32'h1);
      for (int c = 0; c < 6; c++) begin
         tick();
         check_eq("rot.valid", 32'(rr_if.out_valid), 32'h1);
         check_eq("rot.data", 32'(rr_if.out_data), 32'hA0 + 32'(c % 4));
         check_eq("rot.gid", 32'(rr_if.out_grant_id), 32'(c % 4));
      end
      rr_if.req_valid = '0;
      tick();
      check_eq("rot.drain", 32'(rr_if.out_valid), 32'h0);

      // 3: req1 locks the stage, bubbles in the middle, req2 waits
      set_lk(4'b0110, 4'b0100, 32'h00_22_11_00);
      #1;
      check_eq("lock.rdy_b1", 32'(lk_if.req_ready), 32'b0010);
      tick();
      check_lk_out("lock.b1", 1'b1, 8'h11, 1'b0, 2'd1);
      set_lk(4'b0100, 4'b0100, 32'h00_22_00_00);
      for (int c = 0; c < 2; c++) begin
         #1;
         check_eq("lock.rdy_gap", 32'(lk_if.req_ready), 32'b0010);
         tick();
         check_eq("lock.gap_valid", 32'(lk_if.out_valid), 32'h0);
      end
      set_lk(4'b0110, 4'b0100, 32'h00_22_12_00);
      #1;
      check_eq("lock.rdy_b2", 32'(lk_if.req_ready), 32'b0010);
      tick();
      check_lk_out("lock.b2", 1'b1, 8'h12, 1'b0, 2'd1);
      set_lk(4'b0110, 4'b0110, 32'h00_22_13_00);
      #1;
      check_eq("lock.rdy_b3", 32'(lk_if.req_ready), 32'b0010);
      tick();
      check_lk_out("lock.b3", 1'b1, 8'h13, 1'b1, 2'd1);
      check_eq("lock.ptr", 32'(u_lock.ptr_q), 32'd2);
      set_lk(4'b0100, 4'b0100, 32'h00_22_00_00);
      #1;
      check_eq("lock.rdy_r2", 32'(lk_if.req_ready), 32'b0100);
      tick();
      check_lk_out("lock.r2", 1'b1, 8'h22, 1'b1, 2'd2);
      set_lk(4'b0000, 4'b0000, 32'h0);
      tick();
      check_eq("lock.drain", 32'(lk_if.out_valid), 32'h0);

      // 4: backpressure holds the output and withholds ready
      set_lk(4'b0001, 4'b0001, 32'h00_00_00_5C);
      tick();
      check_lk_out("bp.load", 1'b1, 8'h5C, 1'b1, 2'd0);
      set_lk(4'b0001, 4'b0001, 32'h00_00_00_5D);
      lk_if.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check_eq("bp.rdy", 32'(lk_if.req_ready), 32'h0);
         tick();
         check_lk_out("bp.hold", 1'b1, 8'h5C, 1'b1, 2'd0);
      end
      lk_if.out_ready = 1'b1;
      #1;
      check_eq("bp.release_rdy", 32'(lk_if.req_ready), 32'b0001);
      tick();
      check_lk_out("bp.next", 1'b1, 8'h5D, 1'b1, 2'd0);

      // 5: pointer wrap from 3 to 0
      set_lk(4'b0100, 4'b0100, 32'h00_77_00_00);
      tick();
      check_eq("wrap.ptr3", 32'(u_lock.ptr_q), 32'd3);
      set_lk(4'b1001, 4'b1001, 32'h33_00_00_44);
      #1;
      check_eq("wrap.rdy3", 32'(lk_if.req_ready), 32'b1000);
      tick();
      check_lk_out("wrap.g3", 1'b1, 8'h33, 1'b1, 2'd3);
      check_eq("wrap.ptr0", 32'(u_lock.ptr_q), 32'd0);
      #1;
      check_eq("wrap.rdy0", 32'(lk_if.req_ready), 32'b0001);
      tick();
      check_lk_out("wrap.g0", 1'b1, 8'h44, 1'b1, 2'd0);
      check_eq("wrap.ptr1", 32'(u_lock.ptr_q), 32'd1);
      set_lk(4'b0000, 4'b0000, 32'h0);
      tick();

      // 6: asynchronous reset while locked with a beat in flight
      set_lk(4'b0100, 4'b0000, 32'h00_99_00_00);
      tick();
      check_lk_out("rst.pre", 1'b1, 8'h99, 1'b0, 2'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check_lk_out("rst.async", 1'b0, 8'h00, 1'b0, 2'd0);
      #1;
      reset_n = 1'b1;
      set_lk(4'b0111, 4'b0111, 32'h00_03_02_01);
      #1;
      check_eq("rst.rdy", 32'(lk_if.req_ready), 32'b0001);
      tick();
      check_lk_out("rst.restart", 1'b1, 8'h01, 1'b1, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
